// File: rtl/sram_axi_pkg.sv
// rtl/sram_axi_pkg.sv - shared IDs, FSM encodings and fixed AXI fields for the SRAM-to-AXI bridge
package sram_axi_pkg;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_REQ  = 1'b1
    } ar_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_SEND = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    localparam logic [7:0] AXI_LEN   = 8'd0;
    localparam logic [1:0] AXI_BURST = 2'b01;
    localparam logic [1:0] AXI_LOCK  = 2'b00;
    localparam logic [3:0] AXI_CACHE = 4'd0;
    localparam logic [2:0] AXI_PROT  = 3'd0;

endpackage

// File: rtl/sram_axi_bridge_axi_wr_channel.sv
// rtl/sram_axi_bridge_axi_wr_channel.sv - single-outstanding store sequencer driving AW/W/B
// Ports: store request + payload in, accept/idle/done status out, AW and W channels out,
// B channel in. accept is combinational; done pulses in the B handshake cycle.
module axi_wr_channel
    import sram_axi_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        block,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [3:0]  strb,
    input  logic [31:0] data,
    output logic        accept,
    output logic        idle,
    output logic        done,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic        bvalid
);

    w_state_t    state, state_next;
    logic        aw_done, w_done;
    logic        aw_fire, w_fire, b_fire;
    logic [31:0] addr_q, data_q;
    logic [1:0]  size_q;
    logic [3:0]  strb_q;

    assign idle    = (state == W_IDLE);
    assign accept  = idle & req & ~block;
    assign awvalid = (state == W_SEND) & ~aw_done;
    assign wvalid  = (state == W_SEND) & ~w_done;
    assign aw_fire = awvalid & awready;
    assign w_fire  = wvalid & wready;
    assign b_fire  = (state == W_RESP) & bvalid & (bid == ID_DATA);
    assign done    = b_fire;

    assign awid   = ID_DATA;
    assign wid    = ID_DATA;
    assign awaddr = addr_q;
    assign awsize = {1'b0, size_q};
    assign wdata  = data_q;
    assign wstrb  = strb_q;
    assign wlast  = 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= W_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            W_IDLE: if (accept) state_next = W_SEND;
            // A handshake landing in this very cycle counts as done.
            W_SEND: if ((aw_done | aw_fire) & (w_done | w_fire)) state_next = W_RESP;
            W_RESP: if (b_fire) state_next = W_IDLE;
            default: state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            strb_q  <= '0;
        end else if (accept) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            addr_q  <= addr;
            data_q  <= data;
            size_q  <= size;
            strb_q  <= strb;
        end else begin
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
        end
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - arbitrates inst/data SRAM-like ports onto one AXI3 master
// Ports: inst_sram_* fetch port, data_sram_* load/store port, full AXI3 master
// (AR/R/AW/W/B). Reads are tagged by ID; one store in flight at a time.
module sram_axi_bridge
    import sram_axi_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic [31:0] inst_sram_addr,
    input  logic [1:0]  inst_sram_size,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    ar_state_t   ar_state, ar_next;
    logic        inst_pending, data_pending;
    logic        data_rd_sel, inst_sel;
    logic        store_accept, w_idle, store_done;
    logic        ar_holds_data;
    logic [31:0] ar_addr_q;
    logic [1:0]  ar_size_q;
    logic [3:0]  ar_id_q;
    logic        unused_ok;

    assign unused_ok = ^{rresp, bresp};

    assign ar_holds_data = (ar_state == AR_REQ) & (ar_id_q == ID_DATA);

    // A load may not pass an in-flight or just-accepted store (RAW ordering).
    assign data_rd_sel = (ar_state == AR_IDLE) & data_sram_req & ~data_sram_wr
                       & ~data_pending & w_idle & ~store_accept;
    assign inst_sel    = (ar_state == AR_IDLE) & inst_sram_req & ~inst_pending & ~data_rd_sel;

    assign inst_sram_addr_ok = inst_sel;
    assign data_sram_addr_ok = data_rd_sel | store_accept;

    assign inst_sram_data_ok = rvalid & (rid == ID_INST);
    assign data_sram_data_ok = (rvalid & (rid == ID_DATA)) | store_done;
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign arvalid = (ar_state == AR_REQ);
    assign araddr  = ar_addr_q;
    assign arsize  = {1'b0, ar_size_q};
    assign arid    = ar_id_q;
    assign arlen   = AXI_LEN;
    assign arburst = AXI_BURST;
    assign arlock  = AXI_LOCK;
    assign arcache = AXI_CACHE;
    assign arprot  = AXI_PROT;
    assign awlen   = AXI_LEN;
    assign awburst = AXI_BURST;
    assign awlock  = AXI_LOCK;
    assign awcache = AXI_CACHE;
    assign awprot  = AXI_PROT;
    assign rready  = 1'b1;
    assign bready  = 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ar_state <= AR_IDLE;
        else         ar_state <= ar_next;
    end

    always_comb begin
        ar_next = ar_state;
        case (ar_state)
            AR_IDLE: if (data_rd_sel | inst_sel) ar_next = AR_REQ;
            AR_REQ:  if (arready) ar_next = AR_IDLE;
            default: ar_next = AR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_addr_q <= '0;
            ar_size_q <= '0;
            ar_id_q   <= ID_INST;
        end else if (data_rd_sel) begin
            ar_addr_q <= data_sram_addr;
            ar_size_q <= data_sram_size;
            ar_id_q   <= ID_DATA;
        end else if (inst_sel) begin
            ar_addr_q <= inst_sram_addr;
            ar_size_q <= inst_sram_size;
            ar_id_q   <= ID_INST;
        end
    end

    // Set and clear never collide: acceptance requires the flag already clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_pending <= 1'b0;
            data_pending <= 1'b0;
        end else begin
            if (inst_sel) inst_pending <= 1'b1;
            else if (rvalid & rlast & (rid == ID_INST)) inst_pending <= 1'b0;
            if (data_rd_sel) data_pending <= 1'b1;
            else if (rvalid & rlast & (rid == ID_DATA)) data_pending <= 1'b0;
        end
    end

    axi_wr_channel u_wr (
        .clk     (clk),
        .resetn  (resetn),
        .req     (data_sram_req & data_sram_wr),
        .block   (data_pending | ar_holds_data),
        .addr    (data_sram_addr),
        .size    (data_sram_size),
        .strb    (data_sram_wstrb),
        .data    (data_sram_wdata),
        .accept  (store_accept),
        .idle    (w_idle),
        .done    (store_done),
        .awid    (awid),
        .awaddr  (awaddr),
        .awsize  (awsize),
        .awvalid (awvalid),
        .awready (awready),
        .wid     (wid),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bid     (bid),
        .bvalid  (bvalid)
    );

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb/tb_sram_axi_bridge.sv - directed self-checking bench for sram_axi_bridge
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic [1:0]  inst_sram_size;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sram_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        inst_sram_req = 0; inst_sram_addr = 0; inst_sram_size = 2'd2;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2;
        data_sram_wstrb = 0; data_sram_addr = 0; data_sram_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;

        // Reset state
        next_cycle(); sample();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_inst_data_ok", inst_sram_data_ok, 0);
        chk("rst_data_data_ok", data_sram_data_ok, 0);
        chk("rst_rready", rready, 1);
        chk("rst_bready", bready, 1);
        chk("rst_arburst", arburst, 2'b01);
        chk("rst_awlen", awlen, 0);
        next_cycle(); resetn = 1'b1;
        sample();

        // 1: inst-only fetch, arready after 2 cycles
        next_cycle(); inst_sram_req = 1; inst_sram_addr = 32'h1c000000; sample();
        chk("t1_inst_addr_ok", inst_sram_addr_ok, 1);
        chk("t1_arvalid_c0", arvalid, 0);
        next_cycle(); inst_sram_req = 0; sample();
        chk("t1_arvalid_c1", arvalid, 1);
        chk("t1_araddr", araddr, 32'h1c000000);
        chk("t1_arid", arid, 0);
        chk("t1_arsize", arsize, 3'b010);
        next_cycle(); sample();
        chk("t1_arvalid_c2", arvalid, 1);
        next_cycle(); arready = 1; sample();
        chk("t1_arvalid_c3", arvalid, 1);
        next_cycle(); arready = 0; rvalid = 1; rlast = 1; rid = 0; rdata = 32'h02800000; sample();
        chk("t1_arvalid_c4", arvalid, 0);
        chk("t1_inst_data_ok", inst_sram_data_ok, 1);
        chk("t1_inst_rdata", inst_sram_rdata, 32'h02800000);
        chk("t1_data_data_ok", data_sram_data_ok, 0);
        next_cycle(); rvalid = 0; sample();
        chk("t1_inst_data_ok_off", inst_sram_data_ok, 0);

        // 2: simultaneous inst + data read, out-of-order return
        next_cycle();
        inst_sram_req = 1; inst_sram_addr = 32'h1c000000;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h00001004;
        sample();
        chk("t2_data_addr_ok", data_sram_addr_ok, 1);
        chk("t2_inst_addr_ok_c0", inst_sram_addr_ok, 0);
        next_cycle(); data_sram_req = 0; arready = 1; sample();
        chk("t2_arid_data", arid, 1);
        chk("t2_araddr_data", araddr, 32'h00001004);
        chk("t2_inst_addr_ok_c1", inst_sram_addr_ok, 0);
        next_cycle(); arready = 0; sample();
        chk("t2_inst_addr_ok_c2", inst_sram_addr_ok, 1);
        chk("t2_arvalid_c2", arvalid, 0);
        next_cycle(); inst_sram_req = 0; arready = 1; sample();
        chk("t2_arid_inst", arid, 0);
        chk("t2_araddr_inst", araddr, 32'h1c000000);
        next_cycle(); arready = 0; rvalid = 1; rid = 0; rdata = 32'h11111111; sample();
        chk("t2_r0_inst_ok", inst_sram_data_ok, 1);
        chk("t2_r0_data_ok", data_sram_data_ok, 0);
        chk("t2_r0_rdata", inst_sram_rdata, 32'h11111111);
        next_cycle(); rid = 1; rdata = 32'h22222222; sample();
        chk("t2_r1_data_ok", data_sram_data_ok, 1);
        chk("t2_r1_inst_ok", inst_sram_data_ok, 0);
        chk("t2_r1_rdata", data_sram_rdata, 32'h22222222);
        next_cycle(); rvalid = 0; sample();

        // 3: store with staggered AW/W handshakes
        next_cycle();
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h00001000;
        data_sram_wdata = 32'hdeadbeef; data_sram_wstrb = 4'b0011;
        sample();
        chk("t3_addr_ok", data_sram_addr_ok, 1);
        chk("t3_awvalid_c0", awvalid, 0);
        next_cycle(); data_sram_req = 0; awready = 1; sample();
        chk("t3_awvalid_c1", awvalid, 1);
        chk("t3_wvalid_c1", wvalid, 1);
        chk("t3_awaddr", awaddr, 32'h00001000);
        chk("t3_awid", awid, 1);
        chk("t3_wid", wid, 1);
        chk("t3_wdata", wdata, 32'hdeadbeef);
        chk("t3_wstrb", wstrb, 4'b0011);
        chk("t3_wlast", wlast, 1);
        chk("t3_awsize", awsize, 3'b010);
        next_cycle(); awready = 0; sample();
        chk("t3_awvalid_c2", awvalid, 0);
        chk("t3_wvalid_c2", wvalid, 1);
        next_cycle(); wready = 1; sample();
        chk("t3_wvalid_c3", wvalid, 1);
        chk("t3_data_ok_c3", data_sram_data_ok, 0);
        next_cycle(); wready = 0; sample();
        chk("t3_wvalid_c4", wvalid, 0);
        chk("t3_data_ok_c4", data_sram_data_ok, 0);
        next_cycle(); bvalid = 1; bid = 1; sample();
        chk("t3_data_ok_c5", data_sram_data_ok, 1);
        next_cycle(); bvalid = 0; sample();
        chk("t3_data_ok_c6", data_sram_data_ok, 0);

        // 4: RAW - load behind a store waits for the B handshake
        next_cycle();
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h00002000; data_sram_wdata = 32'h5a5a5a5a;
        data_sram_wstrb = 4'hf;
        sample();
        chk("t4_store_ok", data_sram_addr_ok, 1);
        next_cycle(); data_sram_wr = 0; awready = 1; wready = 1; sample();
        chk("t4_load_held_c1", data_sram_addr_ok, 0);
        chk("t4_arvalid_c1", arvalid, 0);
        next_cycle(); awready = 0; wready = 0; sample();
        chk("t4_load_held_c2", data_sram_addr_ok, 0);
        chk("t4_arvalid_c2", arvalid, 0);
        next_cycle(); bvalid = 1; bid = 1; sample();
        chk("t4_b_data_ok", data_sram_data_ok, 1);
        chk("t4_load_held_c3", data_sram_addr_ok, 0);
        chk("t4_arvalid_c3", arvalid, 0);
        next_cycle(); bvalid = 0; sample();
        chk("t4_load_ok", data_sram_addr_ok, 1);
        chk("t4_arvalid_c4", arvalid, 0);
        next_cycle(); data_sram_req = 0; arready = 1; sample();
        chk("t4_arvalid_c5", arvalid, 1);
        chk("t4_araddr", araddr, 32'h00002000);
        chk("t4_arid", arid, 1);

        // 5: data load pending blocks a store; inst fetch still accepted
        next_cycle(); arready = 0;
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h00003000; data_sram_wdata = 32'h01234567;
        inst_sram_req = 1; inst_sram_addr = 32'h1c000040;
        sample();
        chk("t5_store_blocked_c0", data_sram_addr_ok, 0);
        chk("t5_inst_ok", inst_sram_addr_ok, 1);
        chk("t5_awvalid_c0", awvalid, 0);
        next_cycle(); inst_sram_req = 0; arready = 1; sample();
        chk("t5_store_blocked_c1", data_sram_addr_ok, 0);
        chk("t5_arid_inst", arid, 0);
        chk("t5_araddr_inst", araddr, 32'h1c000040);
        next_cycle(); arready = 0; rvalid = 1; rid = 1; rlast = 1; rdata = 32'h33333333; sample();
        chk("t5_load_data_ok", data_sram_data_ok, 1);
        chk("t5_load_rdata", data_sram_rdata, 32'h33333333);
        chk("t5_store_blocked_c2", data_sram_addr_ok, 0);
        next_cycle(); rvalid = 0; sample();
        chk("t5_store_ok", data_sram_addr_ok, 1);
        next_cycle(); data_sram_req = 0; sample();
        chk("t5_awvalid", awvalid, 1);
        chk("t5_wvalid", wvalid, 1);
        chk("t5_awaddr", awaddr, 32'h00003000);

        // 6: asynchronous reset during W_SEND
        #1 resetn = 1'b0;
        #1;
        chk("t6_awvalid_async", awvalid, 0);
        chk("t6_wvalid_async", wvalid, 0);
        chk("t6_arvalid_async", arvalid, 0);
        next_cycle(); resetn = 1'b1;
        sample();
        chk("t6_awvalid_after", awvalid, 0);
        next_cycle(); inst_sram_req = 1; inst_sram_addr = 32'h1c000100; sample();
        chk("t6_inst_ok", inst_sram_addr_ok, 1);
        next_cycle(); inst_sram_req = 0; arready = 1; sample();
        chk("t6_arvalid", arvalid, 1);
        chk("t6_araddr", araddr, 32'h1c000100);
        next_cycle(); arready = 0;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h00004000;
        sample();
        chk("t6_data_rd_ok", data_sram_addr_ok, 1);
        next_cycle(); data_sram_req = 0; sample();
        chk("t6_arid_data", arid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
